// File: rtl/qdma_h2c_arbiter_pkg.sv
// Shared types and constants for the QDMA H2C multi-source arbiter.
package qdma_h2c_arb_pkg;

    localparam int H2C_MTY_W = 6;
    localparam int QID_W     = 11;
    localparam int MDATA_W   = 32;
    localparam int LEN_W     = 16;

    // Sideband carried with every output beat.
    typedef struct packed {
        logic [QID_W-1:0]     qid;
        logic [MDATA_W-1:0]   mdata;
        logic [H2C_MTY_W-1:0] mty;
        logic                 err;
        logic                 zero_byte;
    } h2c_tuser_t;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Single-step modular wrap for indices already below 2*n.
    function automatic int wrap_idx(input int a, input int n);
        return (a >= n) ? (a - n) : a;
    endfunction

endpackage

// File: rtl/qdma_h2c_arbiter_rr_grant.sv
// Combinational round-robin search: first set request at or above ptr, with wrap.
module rr_grant
    import qdma_h2c_arb_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [2:0]         ptr,
    output logic               gnt_valid,
    output logic [2:0]         gnt_idx
);

    logic [NUM_SRC-1:0] rot;

    // Rotate the request vector so bit 0 is the source at ptr.
    always_comb begin
        rot = NUM_SRC'({req, req} >> ptr);
    end

    // Lowest set bit of the rotated vector wins; map it back to a source index.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 3'd0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!gnt_valid && rot[k]) begin
                gnt_valid = 1'b1;
                gnt_idx   = 3'(wrap_idx(int'(ptr) + k, NUM_SRC));
            end
        end
    end

endmodule

// File: rtl/qdma_h2c_arbiter.sv
// Packet-atomic round-robin arbiter sharing the QDMA H2C stream port
// between NUM_SRC sources, with one registered output stage.
//
// Handshake rule on every stream interface here: a beat transfers on a
// rising clock edge where valid and ready are both high; valid, once raised,
// stays high with stable payload until that transfer; ready may depend on
// valid combinationally but valid never depends on ready.
module qdma_h2c_arbiter
    import qdma_h2c_arb_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int DATA_W    = 512,
    parameter int MAX_BEATS = 160
) (
    input  logic                         axis_aclk,
    input  logic                         axis_rst,
    input  logic [NUM_SRC-1:0]           s_axis_tvalid,
    output logic [NUM_SRC-1:0]           s_axis_tready,
    input  logic [NUM_SRC*DATA_W-1:0]    s_axis_tdata,
    input  logic [NUM_SRC-1:0]           s_axis_tlast,
    input  logic [NUM_SRC*H2C_MTY_W-1:0] s_axis_tuser_mty,
    input  logic [NUM_SRC*QID_W-1:0]     s_axis_tuser_qid,
    input  logic [NUM_SRC*LEN_W-1:0]     s_axis_tuser_len,
    output logic                         m_axis_h2c_tvalid,
    input  logic                         m_axis_h2c_tready,
    output logic [DATA_W-1:0]            m_axis_h2c_tdata,
    output logic                         m_axis_h2c_tlast,
    output logic [QID_W-1:0]             m_axis_h2c_tuser_qid,
    output logic [MDATA_W-1:0]           m_axis_h2c_tuser_mdata,
    output logic [H2C_MTY_W-1:0]         m_axis_h2c_tuser_mty,
    output logic                         m_axis_h2c_tuser_err,
    output logic                         m_axis_h2c_tuser_zero_byte,
    output logic [2:0]                   grant_id,
    output logic                         busy,
    output logic [31:0]                  pkt_cnt,
    output logic [15:0]                  err_cnt
);

    localparam int BEAT_W = $clog2(MAX_BEATS + 1);

    arb_state_e           state, state_nxt;
    logic [2:0]           grant_q;
    logic [2:0]           rr_ptr;
    logic [BEAT_W-1:0]    beat_cnt;
    logic [QID_W-1:0]     qid_lat;
    logic [LEN_W-1:0]     len_lat;

    logic                 gnt_valid;
    logic [2:0]           gnt_idx;

    logic                 sel_valid;
    logic                 sel_last;
    logic [DATA_W-1:0]    sel_data;
    logic [H2C_MTY_W-1:0] sel_mty;
    logic [QID_W-1:0]     sel_qid;
    logic [LEN_W-1:0]     sel_len;

    logic                 out_valid;
    logic [DATA_W-1:0]    out_data;
    logic                 out_last;
    h2c_tuser_t           out_user;
    h2c_tuser_t           beat_user;

    logic                 out_free;
    logic                 accept;
    logic                 first_beat;
    logic                 at_limit;
    logic                 beat_last;
    logic                 pkt_end;
    logic                 out_fire;

    rr_grant #(
        .NUM_SRC (NUM_SRC)
    ) u_rr_grant (
        .req       (s_axis_tvalid),
        .ptr       (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Gather the locked source's beat and sideband.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_mty   = '0;
        sel_qid   = '0;
        sel_len   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == 3'(i)) begin
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
                sel_data  = s_axis_tdata[i*DATA_W +: DATA_W];
                sel_mty   = s_axis_tuser_mty[i*H2C_MTY_W +: H2C_MTY_W];
                sel_qid   = s_axis_tuser_qid[i*QID_W +: QID_W];
                sel_len   = s_axis_tuser_len[i*LEN_W +: LEN_W];
            end
        end
    end

    assign out_free   = !out_valid || m_axis_h2c_tready;
    assign accept     = (state == LOCK) && sel_valid && out_free;
    assign first_beat = (beat_cnt == '0);
    // The MAX_BEATS-th beat of a packet always closes it, tlast or not.
    assign at_limit   = (beat_cnt == BEAT_W'(MAX_BEATS - 1));
    assign beat_last  = sel_last || at_limit;
    assign pkt_end    = accept && beat_last;
    assign out_fire   = out_valid && m_axis_h2c_tready;

    // Only the locked source sees ready, and only when the output stage can take a beat.
    always_comb begin
        s_axis_tready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            s_axis_tready[i] = (state == LOCK) && (grant_q == 3'(i)) && out_free;
        end
    end

    // Build the output sideband for the beat being accepted.
    always_comb begin
        beat_user.qid       = sel_qid;
        beat_user.mdata     = MDATA_W'(sel_len);
        beat_user.mty       = sel_last ? sel_mty : '0;
        beat_user.err       = (!sel_last && (sel_mty != '0))
                            || (!first_beat && ((sel_qid != qid_lat) || (sel_len != len_lat)))
                            || (!sel_last && at_limit);
        beat_user.zero_byte = first_beat ? (sel_len == '0) : (len_lat == '0);
    end

    // FSM state register.
    always_ff @(posedge axis_aclk or posedge axis_rst) begin
        if (axis_rst) state <= IDLE;
        else          state <= state_nxt;
    end

    // FSM next state: arbitrate in IDLE, hold the lock until the packet closes.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_valid) state_nxt = LOCK;
            LOCK:    if (pkt_end)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant capture and round-robin pointer advance past the finished source.
    always_ff @(posedge axis_aclk or posedge axis_rst) begin
        if (axis_rst) begin
            grant_q <= 3'd0;
            rr_ptr  <= 3'd0;
        end else begin
            if (state == IDLE && gnt_valid) grant_q <= gnt_idx;
            if (pkt_end) rr_ptr <= 3'(wrap_idx(int'(grant_q) + 1, NUM_SRC));
        end
    end

    // Per-packet beat count and first-beat qid/len reference.
    always_ff @(posedge axis_aclk or posedge axis_rst) begin
        if (axis_rst) begin
            beat_cnt <= '0;
            qid_lat  <= '0;
            len_lat  <= '0;
        end else if (accept) begin
            beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
            if (first_beat) begin
                qid_lat <= sel_qid;
                len_lat <= sel_len;
            end
        end
    end

    // Output register: load on accept, hold under backpressure, drop on drain.
    always_ff @(posedge axis_aclk or posedge axis_rst) begin
        if (axis_rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_user  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= beat_last;
            out_user  <= beat_user;
        end else if (m_axis_h2c_tready) begin
            out_valid <= 1'b0;
        end
    end

    // Completed-packet (wrapping) and error-beat (saturating) counters.
    always_ff @(posedge axis_aclk or posedge axis_rst) begin
        if (axis_rst) begin
            pkt_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (out_fire && out_last) pkt_cnt <= pkt_cnt + 32'd1;
            if (out_fire && out_user.err && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
        end
    end

    assign m_axis_h2c_tvalid          = out_valid;
    assign m_axis_h2c_tdata           = out_data;
    assign m_axis_h2c_tlast           = out_last;
    assign m_axis_h2c_tuser_qid       = out_user.qid;
    assign m_axis_h2c_tuser_mdata     = out_user.mdata;
    assign m_axis_h2c_tuser_mty       = out_user.mty;
    assign m_axis_h2c_tuser_err       = out_user.err;
    assign m_axis_h2c_tuser_zero_byte = out_user.zero_byte;
    assign grant_id                   = grant_q;
    assign busy                       = (state == LOCK);

endmodule

// File: tb/tb_qdma_h2c_arbiter.sv
// Bench for qdma_h2c_arbiter: per-source beat queues drive the inputs, a
// per-source packet model predicts every output beat.
module tb_qdma_h2c_arbiter;

    localparam int NUM_SRC   = 4;
    localparam int DATA_W    = 512;
    localparam int MAX_BEATS = 160;
    localparam int IW        = DATA_W + 1 + 6 + 11 + 16;          // {data,last,mty,qid,len}
    localparam int EW        = DATA_W + 1 + 6 + 1 + 11 + 32 + 1; // {data,last,mty,err,qid,mdata,zb}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NUM_SRC-1:0]        s_tvalid;
    logic [NUM_SRC-1:0]        s_tready;
    logic [NUM_SRC*DATA_W-1:0] s_tdata;
    logic [NUM_SRC-1:0]        s_tlast;
    logic [NUM_SRC*6-1:0]      s_mty;
    logic [NUM_SRC*11-1:0]     s_qid;
    logic [NUM_SRC*16-1:0]     s_len;
    logic                      m_valid;
    logic                      m_tready;
    logic [DATA_W-1:0]         m_tdata;
    logic                      m_tlast;
    logic [10:0]               m_qid;
    logic [31:0]               m_mdata;
    logic [5:0]                m_mty;
    logic                      m_err;
    logic                      m_zb;
    logic [2:0]                grant_id;
    logic                      busy;
    logic [31:0]               pkt_cnt;
    logic [15:0]               err_cnt;

    qdma_h2c_arbiter #(
        .NUM_SRC   (NUM_SRC),
        .DATA_W    (DATA_W),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .axis_aclk                  (clk),
        .axis_rst                   (rst),
        .s_axis_tvalid              (s_tvalid),
        .s_axis_tready              (s_tready),
        .s_axis_tdata               (s_tdata),
        .s_axis_tlast               (s_tlast),
        .s_axis_tuser_mty           (s_mty),
        .s_axis_tuser_qid           (s_qid),
        .s_axis_tuser_len           (s_len),
        .m_axis_h2c_tvalid          (m_valid),
        .m_axis_h2c_tready          (m_tready),
        .m_axis_h2c_tdata           (m_tdata),
        .m_axis_h2c_tlast           (m_tlast),
        .m_axis_h2c_tuser_qid       (m_qid),
        .m_axis_h2c_tuser_mdata     (m_mdata),
        .m_axis_h2c_tuser_mty       (m_mty),
        .m_axis_h2c_tuser_err       (m_err),
        .m_axis_h2c_tuser_zero_byte (m_zb),
        .grant_id                   (grant_id),
        .busy                       (busy),
        .pkt_cnt                    (pkt_cnt),
        .err_cnt                    (err_cnt)
    );

    // ---------------- bench state ----------------
    logic [IW-1:0] drv_q [NUM_SRC][$];
    logic [EW-1:0] exp_q [NUM_SRC][$];
    int            m_cnt [NUM_SRC];
    logic [10:0]   m_qid_l [NUM_SRC];
    logic [15:0]   m_len_l [NUM_SRC];

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [NUM_SRC-1:0] hs_src = '0;
    logic          hs_out = 1'b0;
    logic [EW-1:0] out_cap;
    int            valid_pct = 100;
    int            rdy_mode  = 0;  // 0: always ready, 1: toggle, 2: random
    bit            rdy_tog   = 1'b1;
    int            lock_src  = -1;
    bit            rr_mode   = 1'b0;
    int            rr_exp    = 0;
    int            cyc       = 0;
    int            last_out_cyc = -1;
    logic [31:0]   exp_pkt = '0;
    logic [15:0]   exp_err = '0;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [DATA_W-1:0] rand_data(input int s);
        logic [DATA_W-1:0] d;
        for (int k = 0; k < DATA_W/32; k++) d[k*32 +: 32] = $urandom;
        d[DATA_W-1 -: 4] = 4'(s);
        return d;
    endfunction

    // Queue one source beat and predict the output beat it becomes.
    task automatic add_beat(input int s, input logic [DATA_W-1:0] data, input bit last,
                            input logic [5:0] mty, input logic [10:0] qid, input logic [15:0] len);
        bit first, forced, olast, err, zb;
        logic [5:0] omty;
        drv_q[s].push_back({data, last, mty, qid, len});
        first = (m_cnt[s] == 0);
        if (first) begin
            m_qid_l[s] = qid;
            m_len_l[s] = len;
        end
        forced = !last && (m_cnt[s] + 1 == MAX_BEATS);
        olast  = last || forced;
        err    = (!last && mty != 0) || (!first && (qid != m_qid_l[s] || len != m_len_l[s])) || forced;
        zb     = (m_len_l[s] == 16'd0);
        omty   = last ? mty : 6'd0;
        exp_q[s].push_back({data, olast, omty, err, qid, 32'(len), zb});
        m_cnt[s] = olast ? 0 : m_cnt[s] + 1;
    endtask

    task automatic add_packet(input int s, input int nbeats, input logic [15:0] len,
                              input logic [10:0] qid, input logic [5:0] last_mty);
        for (int b = 0; b < nbeats; b++)
            add_beat(s, rand_data(s), b == nbeats - 1, (b == nbeats - 1) ? last_mty : 6'd0, qid, len);
    endtask

    // Match one observed output beat against its source's expected queue.
    task automatic score(input logic [EW-1:0] got);
        int s;
        logic [EW-1:0] e;
        s = int'(got[EW-1 -: 4]);
        if (s >= NUM_SRC) begin
            check("src_id_range", s, 0);
        end else if (exp_q[s].size() == 0) begin
            check("exp_avail", exp_q[s].size(), 1);
        end else begin
            e = exp_q[s].pop_front();
            check("beat", got, e);
            if (lock_src >= 0) check("atomic", s, lock_src);
            if (lock_src < 0 && rr_mode) begin
                check("rr_order", s, rr_exp);
                rr_exp = (rr_exp + 1) % NUM_SRC;
            end
            if (rr_mode && last_out_cyc >= 0) check("rr_gap", cyc - last_out_cyc, 2);
            last_out_cyc = cyc;
            lock_src = e[51] ? -1 : s;
            if (e[51]) exp_pkt = exp_pkt + 32'd1;
            if (e[44] && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
        end
    endtask

    // ---------------- driver ----------------
    // One clock: retire last edge's handshakes, drive new inputs at negedge, sample at negedge+1.
    task automatic step();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NUM_SRC; i++) if (hs_src[i]) void'(drv_q[i].pop_front());
        if (|hs_src) check("latency", m_valid, 1);
        if (hs_out) score(out_cap);
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       begin m_tready = rdy_tog; rdy_tog = !rdy_tog; end
            default: m_tready = ($urandom_range(0, 3) != 0);
        endcase
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!(s_tvalid[i] && !hs_src[i])) begin
                if (drv_q[i].size() > 0 && $urandom_range(0, 99) < valid_pct) begin
                    s_tvalid[i] = 1'b1;
                    {s_tdata[i*DATA_W +: DATA_W], s_tlast[i], s_mty[i*6 +: 6],
                     s_qid[i*11 +: 11], s_len[i*16 +: 16]} = drv_q[i][0];
                end else begin
                    s_tvalid[i] = 1'b0;
                end
            end
        end
        #1;
        hs_src  = s_tvalid & s_tready;
        hs_out  = m_valid && m_tready;
        out_cap = {m_tdata, m_tlast, m_mty, m_err, m_qid, m_mdata, m_zb};
        if (m_valid && !m_tready) check("stall_ready", s_tready, 0);
    endtask

    function automatic bit all_idle();
        bit r;
        r = !hs_out && (hs_src == '0) && !m_valid;
        for (int i = 0; i < NUM_SRC; i++) if (drv_q[i].size() != 0 || exp_q[i].size() != 0) r = 1'b0;
        return r;
    endfunction

    task automatic drain(input int budget, input string tag);
        int n;
        n = 0;
        while (!all_idle() && n < budget) begin
            step();
            n++;
        end
        check({tag, "_drained"}, all_idle(), 1);
    endtask

    task automatic clear_model();
        for (int i = 0; i < NUM_SRC; i++) begin
            drv_q[i].delete();
            exp_q[i].delete();
            m_cnt[i] = 0;
        end
        s_tvalid = '0;
        hs_src   = '0;
        hs_out   = 1'b0;
        lock_src = -1;
        exp_pkt  = '0;
        exp_err  = '0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2ms;
        $display("FAIL watchdog sim_time got=expired exp=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int s, nb;
        logic [15:0] len;
        logic [10:0] qid;
        logic [5:0]  mty;
        logic [DATA_W-1:0] d;

        s_tvalid = '0; s_tdata = '0; s_tlast = '0; s_mty = '0; s_qid = '0; s_len = '0;
        m_tready = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_s_tready", s_tready, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_out", {m_tdata, m_tlast, m_mty, m_err, m_qid, m_mdata, m_zb}, 0);
        rst = 1'b0;

        // All sources continuously valid, 1-beat packets: strict 0,1,2,3 rotation.
        rr_mode = 1'b1; rr_exp = 0; last_out_cyc = -1;
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < NUM_SRC; i++) add_packet(i, 1, 16'd64, 11'(16 + i), 6'd0);
        drain(400, "rr");
        rr_mode = 1'b0;
        check("rr_pkt_cnt", pkt_cnt, exp_pkt);

        // Source 0, 100-byte 2-beat packet.
        add_packet(0, 2, 16'd100, 11'd5, 6'd28);
        drain(100, "single");
        check("single_pkt_cnt", pkt_cnt, exp_pkt);
        check("single_err_cnt", err_cnt, exp_err);

        // Toggling downstream ready during a 5-beat packet.
        rdy_mode = 1;
        add_packet(3, 5, 16'd300, 11'd77, 6'd20);
        drain(100, "toggle");
        rdy_mode = 0;
        check("toggle_pkt_cnt", pkt_cnt, exp_pkt);

        // Source 2: nonzero mty on a non-last beat, then a qid change.
        add_beat(2, rand_data(2), 1'b0, 6'd5, 11'd200, 16'd120);
        add_beat(2, rand_data(2), 1'b1, 6'd8, 11'd201, 16'd120);
        drain(100, "errs");
        check("errs_err_cnt", err_cnt, exp_err);
        check("errs_pkt_cnt", pkt_cnt, exp_pkt);

        // 170-beat packet: truncated at beat MAX_BEATS, remainder is a new packet.
        add_packet(1, 170, 16'd10880, 11'd300, 6'd0);
        drain(600, "trunc");
        check("trunc_pkt_cnt", pkt_cnt, exp_pkt);
        check("trunc_err_cnt", err_cnt, exp_err);

        // Random traffic on all sources with gaps and backpressure.
        valid_pct = 70; rdy_mode = 2;
        for (int n = 0; n < 40; n++) begin
            s   = $urandom_range(0, NUM_SRC - 1);
            nb  = $urandom_range(1, 6);
            len = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 384));
            qid = 11'($urandom);
            for (int b = 0; b < nb; b++) begin
                if (b == nb - 1) mty = 6'($urandom);
                else mty = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
                d = rand_data(s);
                add_beat(s, d, b == nb - 1, mty, qid, len);
            end
        end
        drain(4000, "random");
        check("random_pkt_cnt", pkt_cnt, exp_pkt);
        check("random_err_cnt", err_cnt, exp_err);

        // Reset in the middle of a source 1 packet.
        valid_pct = 100; rdy_mode = 0;
        add_packet(1, 6, 16'd384, 11'd9, 6'd0);
        repeat (4) step();
        check("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_s_tready", s_tready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_grant_id", grant_id, 0);
        check("mid_rst_pkt_cnt", pkt_cnt, 0);
        check("mid_rst_err_cnt", err_cnt, 0);
        check("mid_rst_out", {m_tdata, m_tlast, m_mty, m_err, m_qid, m_mdata, m_zb}, 0);
        clear_model();
        @(negedge clk);
        rst = 1'b0;
        rr_mode = 1'b1; rr_exp = 0; last_out_cyc = -1;
        add_packet(1, 1, 16'd32, 11'd1, 6'd0);
        add_packet(0, 1, 16'd32, 11'd0, 6'd0);
        drain(100, "post_rst");
        rr_mode = 1'b0;
        check("post_rst_pkt_cnt", pkt_cnt, exp_pkt);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qdma_h2c_arbiter.md
Name: qdma_h2c_arbiter

Overview:
- Shares the single QDMA H2C AXI-Stream master port between NUM_SRC packet sources (per-queue generators, test drivers).
- Packet-atomic round-robin arbiter feeding one registered output stage.
- Output carries the QDMA H2C sideband: qid, mdata (packet length in bytes), mty, err, zero_byte.
- Sits between the per-queue sources and the shell's H2C input, in place of a single-source driver.

Parameters:
- NUM_SRC, 4, number of requesters (2..8).
- DATA_W, 512, stream data width in bits; mty is log2(DATA_W/8) = 6 bits.
- MAX_BEATS, 160, maximum beats per packet before the arbiter truncates it.

Ports:
- axis_aclk  in  1  sole clock.
- axis_rst  in  1  asynchronous, active-high reset.
- s_axis_tvalid  in  NUM_SRC  per-source beat valid.
- s_axis_tready  out  NUM_SRC  per-source beat accept.
- s_axis_tdata  in  NUM_SRC*DATA_W  per-source data; source i in slice i.
- s_axis_tlast  in  NUM_SRC  end of packet.
- s_axis_tuser_mty  in  NUM_SRC*6  empty bytes, valid on the last beat only.
- s_axis_tuser_qid  in  NUM_SRC*11  queue id; constant within a packet.
- s_axis_tuser_len  in  NUM_SRC*16  packet length in bytes; constant within a packet.
- m_axis_h2c_tvalid  out  1  output beat valid.
- m_axis_h2c_tready  in  1  downstream accept.
- m_axis_h2c_tdata  out  DATA_W  output data.
- m_axis_h2c_tlast  out  1  output end of packet.
- m_axis_h2c_tuser_qid  out  11  queue id.
- m_axis_h2c_tuser_mdata  out  32  zero-extended packet length.
- m_axis_h2c_tuser_mty  out  6  empty bytes.
- m_axis_h2c_tuser_err  out  1  per-beat protocol error.
- m_axis_h2c_tuser_zero_byte  out  1  packet length equals 0.
- grant_id  out  3  index of the currently locked source.
- busy  out  1  a packet is locked.
- pkt_cnt  out  32  packets completed at the output; wraps.
- err_cnt  out  16  error beats; saturates at 0xFFFF.

Behaviour:
- Reset (asynchronous, active-high): all of the following are 0:
  - m_axis_h2c_tvalid and every m_axis_h2c_* field;
  - s_axis_tready;
  - grant_id, busy, pkt_cnt, err_cnt;
  - round-robin pointer rr_ptr;
  - beat counter.
- State machine: IDLE, LOCK.
- IDLE:
  - If any s_axis_tvalid is set, grant the first valid source searching from rr_ptr upward with wrap.
  - Go to LOCK the same cycle the grant registers. busy=1, grant_id=source.
  - No beat is accepted in the arbitration cycle.
- LOCK:
  - s_axis_tready[g] = !out_valid || m_axis_h2c_tready. All other s_axis_tready bits are 0.
  - Each accepted beat is loaded into the output register: 1-cycle latency from source handshake to m_axis_h2c_tvalid.
  - Output fields are loaded with the beat.
  - On an accepted beat with tlast=1: go to IDLE and set rr_ptr = (g+1) mod NUM_SRC. The arbiter may re-grant on the next cycle.
- Output register:
  - Holds its contents while m_axis_h2c_tvalid && !m_axis_h2c_tready.
  - Clears tvalid on a downstream accept unless a new beat loads the same cycle.
  - Back-to-back beats run at full throughput.
- mty handling: output mty = source mty on the last beat, forced to 0 on non-last beats.
- tuser_err = 1 on a beat when either condition holds:
  - nonzero source mty on a non-last beat;
  - qid or len differs from the value latched at the first beat.
- err_cnt increments per err beat, at the output handshake.
- zero_byte = (len == 0), held for the whole packet.
- Beat counter:
  - Counts beats accepted in the current packet.
  - On the MAX_BEATS-th beat without tlast, the arbiter forces tlast=1 and err=1 on that output beat and returns to IDLE.
  - The source's remaining beats are then arbitrated as a new packet.
- pkt_cnt increments at each output handshake with tlast=1; wraps from 0xFFFFFFFF to 0.
- Source tvalid deasserting mid-packet stalls the lock; no timeout.
- Simultaneous tvalid from all sources, starting from rr_ptr=0, grants in order 0,1,2,3,0.
- Reset mid-packet discards the output register and the lock; sources must restart packets after reset.

Decomposition:
- Package qdma_h2c_arb_pkg holds:
  - H2C_MTY_W=6, QID_W=11, MDATA_W=32;
  - typedef h2c_tuser_t, a packed struct of qid, mdata, mty, err, zero_byte;
  - typedef arb_state_e {IDLE, LOCK}.
- One sub-module, rr_grant, is natural: combinational round-robin first-set search over NUM_SRC, given rr_ptr.

Test Plan:
- Single source 0, 100-byte packet: 2 beats, second beat mty=28 → output beat 0 has mdata=100, mty=0, tlast=0; beat 1 has mty=28, tlast=1; pkt_cnt=1; latency 1 cycle after the handshake.
- All 4 sources continuously valid, 1-beat packets → grant order 0,1,2,3,0,1, with one IDLE arbitration cycle between packets.
- m_axis_h2c_tready toggles 1010… during a 5-beat packet → data is not duplicated or lost, beats arrive in order, source stalls while the output register is full.
- Source 2 sends mty=5 on a non-last beat, then changes qid mid-packet → err=1 on both beats, err_cnt=2, packet still delivered.
- 170-beat packet with no tlast before beat 170 → forced tlast and err on output beat 160; next grant handles the remaining 10 beats; pkt_cnt=2.
- axis_rst asserted mid-packet on source 1 → all outputs 0 immediately; after release, rr_ptr=0 and source 0 is served first.
